// File: rtl/ctrl_pkg.sv
// Shared control-bus bit indices, opcode constants and helpers for the OF->EX control stage.
package ctrl_pkg;

  localparam int CTRL_W = 22;

  localparam int B_ST   = 0;
  localparam int B_LD   = 1;
  localparam int B_BEQ  = 2;
  localparam int B_BGT  = 3;
  localparam int B_RET  = 4;
  localparam int B_IMM  = 5;
  localparam int B_WB   = 6;
  localparam int B_UBR  = 7;
  localparam int B_CALL = 8;
  localparam int B_ADD  = 9;
  localparam int B_SUB  = 10;
  localparam int B_CMP  = 11;
  localparam int B_MUL  = 12;
  localparam int B_DIV  = 13;
  localparam int B_MOD  = 14;
  localparam int B_LSL  = 15;
  localparam int B_LSR  = 16;
  localparam int B_ASR  = 17;
  localparam int B_OR   = 18;
  localparam int B_AND  = 19;
  localparam int B_NOT  = 20;
  localparam int B_MOV  = 21;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_RSVD = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  function automatic logic is_muldiv(input logic [CTRL_W-1:0] ctrl);
    return ctrl[B_MUL] | ctrl[B_DIV] | ctrl[B_MOD];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: top six instruction bits (op5..op1, I) to the 22-bit control bus.
// With CTRL_ILLEGAL_TRAP_EN defined it also flags unlisted opcodes.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]        instr_hi,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic              illegal,
`endif
  output logic [CTRL_W-1:0] ctrl
);

  logic [4:0] op;
  assign op = instr_hi[5:1];

  always_comb begin
    ctrl = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal = 1'b0;
`endif
    ctrl[B_IMM] = instr_hi[0];
    // Writeback covers the whole ALU/load half of the map, plus call (link register)
    ctrl[B_WB]  = (!op[4] && op != OP_CMP && op != OP_RSVD && op != OP_ST) || (op == OP_CALL);
    case (op)
      OP_ADD:  ctrl[B_ADD] = 1'b1;
      OP_SUB:  ctrl[B_SUB] = 1'b1;
      OP_MUL:  ctrl[B_MUL] = 1'b1;
      OP_DIV:  ctrl[B_DIV] = 1'b1;
      OP_MOD:  ctrl[B_MOD] = 1'b1;
      OP_CMP:  ctrl[B_CMP] = 1'b1;
      OP_AND:  ctrl[B_AND] = 1'b1;
      OP_OR:   ctrl[B_OR]  = 1'b1;
      OP_NOT:  ctrl[B_NOT] = 1'b1;
      OP_MOV:  ctrl[B_MOV] = 1'b1;
      OP_LSL:  ctrl[B_LSL] = 1'b1;
      OP_LSR:  ctrl[B_LSR] = 1'b1;
      OP_ASR:  ctrl[B_ASR] = 1'b1;
      OP_LD:   ctrl[B_LD]  = 1'b1;
      OP_ST:   begin
        ctrl[B_ST]  = 1'b1;
        ctrl[B_ADD] = 1'b1;
      end
      OP_BEQ:  ctrl[B_BEQ] = 1'b1;
      OP_BGT:  ctrl[B_BGT] = 1'b1;
      OP_B:    ctrl[B_UBR] = 1'b1;
      OP_CALL: begin
        ctrl[B_CALL] = 1'b1;
        ctrl[B_UBR]  = 1'b1;
      end
      OP_RET:  begin
        ctrl[B_RET] = 1'b1;
        ctrl[B_UBR] = 1'b1;
      end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// One-stage OF->EX control pipeline: valid/ready bundle register, flush, MUL/DIV/MOD bubble throttling.
// Optional CTRL_ILLEGAL_TRAP_EN adds illegal_op (registered) and sticky illegal_seen outputs.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int PC_W       = 32,
  parameter int MULDIV_LAT = 4
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic               illegal_op,
  output logic               illegal_seen,
`endif
  output logic [CTRL_W-1:0]  ctrl_bus,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  localparam int BUSY_W = $clog2(MULDIV_LAT) + 1;
  localparam logic [BUSY_W-1:0] BUSY_RELOAD = BUSY_W'(MULDIV_LAT - 1);

  logic               v_q, v_d;
  logic [BUSY_W-1:0]  busy_q, busy_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CTRL_W-1:0]  dec_ctrl;
  logic               idle, load, fire;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic dec_illegal;
  logic illegal_q, illegal_d;
  logic seen_q, seen_d;
`endif

  ctrl_decode u_decode (
    .instr_hi (in_instr[INSTR_W-1 -: 6]),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal  (dec_illegal),
`endif
    .ctrl     (dec_ctrl)
  );

  assign idle      = (busy_q == '0);
  assign out_valid = v_q & idle;
  assign in_ready  = ~flush & idle & (~v_q | out_ready);
  assign load      = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  always_comb begin
    v_d     = v_q;
    busy_d  = busy_q;
    ctrl_d  = ctrl_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (load) begin
      ctrl_d  = dec_ctrl;
      instr_d = in_instr;
      pc_d    = in_pc;
    end
    if (flush) begin
      v_d    = 1'b0;
      busy_d = '0;
    end else begin
      if (load)      v_d = 1'b1;
      else if (fire) v_d = 1'b0;
      // A bundle loaded alongside a firing MUL/DIV/MOD waits out the bubbles in v_q
      if (fire && is_muldiv(ctrl_q)) busy_d = BUSY_RELOAD;
      else if (!idle)                busy_d = busy_q - BUSY_W'(1);
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_comb begin
    illegal_d = illegal_q;
    if (load) illegal_d = dec_illegal;
    seen_d = seen_q | (fire & illegal_q);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q     <= 1'b0;
      busy_q  <= '0;
      ctrl_q  <= '0;
      instr_q <= '0;
      pc_q    <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
      seen_q    <= 1'b0;
`endif
    end else begin
      v_q     <= v_d;
      busy_q  <= busy_d;
      ctrl_q  <= ctrl_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
      seen_q    <= seen_d;
`endif
    end
  end

  assign ctrl_bus  = ctrl_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_op   = illegal_q;
  assign illegal_seen = seen_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit (default parameters; illegal-trap checks when CTRL_ILLEGAL_TRAP_EN is defined).
module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid;
  logic [21:0] ctrl_bus;
  logic [31:0] out_instr, out_pc;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegal_op, illegal_seen;
`endif

  pipelined_control_unit #(.INSTR_W(32), .PC_W(32), .MULDIV_LAT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_op   (illegal_op),
    .illegal_seen (illegal_seen),
`endif
    .ctrl_bus  (ctrl_bus),
    .out_instr (out_instr),
    .out_pc    (out_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [21:0] ctrl;
    logic [31:0] instr;
    logic [31:0] pc;
  } bundle_t;

  bundle_t sb_q[$];
  bundle_t exp_q[$];
  bundle_t obs_q[$];
  logic [21:0] drv_ctrl;
  int checks = 0;
  int errors = 0;

  logic        s_in_ready, s_out_valid, s_fired, s_acc;
  logic [21:0] s_ctrl;
  logic [31:0] s_instr, s_pc;

  // One clock: sample at negedge, update scoreboard, return at posedge+1 ready to drive
  task automatic advance();
    bundle_t e;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_ctrl      = ctrl_bus;
    s_instr     = out_instr;
    s_pc        = out_pc;
    s_fired     = out_valid && out_ready;
    s_acc       = in_valid && in_ready;
    if (s_fired) begin
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else                 e = 'x;
      exp_q.push_back(e);
      obs_q.push_back({ctrl_bus, out_instr, out_pc});
    end
    if (flush) sb_q.delete();
    if (s_acc) sb_q.push_back({drv_ctrl, in_instr, in_pc});
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [21:0] c);
    int n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    drv_ctrl = c;
    do begin
      advance();
      n++;
    end while (!s_acc && n < 50);
    in_valid = 1'b0;
    if (!s_acc) begin
      errors++;
      $display("FAIL send_timeout instr=%h not accepted within 50 cycles", ins);
    end
  endtask

  task automatic flush_out(input int budget);
    int n = 0;
    while (sb_q.size() > 0 && n < budget) begin
      advance();
      n++;
    end
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout %0d bundles still held after %0d cycles", sb_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    bundle_t e, o;
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; drv_ctrl = '0;
    advance();
    advance();
    checks++;
    if ({s_out_valid, s_ctrl, s_instr, s_pc} !== '0) begin
      errors++;
      $display("FAIL reset_state got valid=%b ctrl=%h instr=%h pc=%h want all zero", s_out_valid, s_ctrl, s_instr, s_pc);
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    checks++;
    if ({illegal_op, illegal_seen} !== 2'b00) begin
      errors++;
      $display("FAIL reset_illegal got op=%b seen=%b want 0 0", illegal_op, illegal_seen);
    end
`endif
    reset = 1'b1;
    send(32'h0800_0000, 32'h10, 22'h000440);
    advance();
    checks++;
    if (s_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL held_before_reset got out_valid=%b want 1", s_out_valid);
    end
    reset = 1'b0;
    #2;
    checks++;
    if ({out_valid, ctrl_bus, out_instr, out_pc} !== '0) begin
      errors++;
      $display("FAIL async_reset got valid=%b ctrl=%h instr=%h pc=%h want all zero", out_valid, ctrl_bus, out_instr, out_pc);
    end
    sb_q.delete();
    advance();
    reset = 1'b1;
    out_ready = 1'b1;
    send(32'h0000_0000, 32'h20, 22'h000240);
    advance();
    checks++;
    if (s_fired !== 1'b1) begin
      errors++;
      $display("FAIL first_latency got fire=%b one cycle after load want 1", s_fired);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_bundle got ctrl=%h instr=%h pc=%h want ctrl=%h instr=%h pc=%h", o.ctrl, o.instr, o.pc, e.ctrl, e.instr, e.pc);
      end
    end
  endtask

  task automatic test_decode_sweep();
    logic [31:0] ins [27];
    logic [21:0] cv  [27];
    bundle_t e, o;
    ins = '{32'h00000000, 32'h08000000, 32'h10000000, 32'h18000000, 32'h20000000,
            32'h28000000, 32'h30000000, 32'h38000000, 32'h40000000, 32'h48000000,
            32'h50000000, 32'h58000000, 32'h60000000, 32'h68000000, 32'h70000000,
            32'h78000000, 32'h80000000, 32'h88000000, 32'h90000000, 32'h98000000,
            32'hA0000000, 32'hF8000000, 32'h7C000000, 32'h04000000, 32'hAC000000,
            32'h6C000000, 32'h00ABCDEF};
    cv  = '{22'h000240, 22'h000440, 22'h001040, 22'h002040, 22'h004040,
            22'h000800, 22'h080040, 22'h040040, 22'h100040, 22'h200040,
            22'h008040, 22'h010040, 22'h020040, 22'h000000, 22'h000042,
            22'h000201, 22'h000004, 22'h000008, 22'h000080, 22'h0001C0,
            22'h000090, 22'h000000, 22'h000221, 22'h000260, 22'h000020,
            22'h000020, 22'h000240};
    out_ready = 1'b1;
    for (int i = 0; i < 27; i++) send(ins[i], 32'h1000 + 32'(i * 4), cv[i]);
    flush_out(100);
    checks++;
    if (exp_q.size() != 27) begin
      errors++;
      $display("FAIL sweep_count got %0d fires want 27", exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sweep_bundle got ctrl=%h instr=%h pc=%h want ctrl=%h instr=%h pc=%h", o.ctrl, o.instr, o.pc, e.ctrl, e.instr, e.pc);
      end
    end
  endtask

  task automatic test_muldiv();
    bundle_t e, o;
    out_ready = 1'b1;
    send(32'h1000_0000, 32'h200, 22'h001040);
    send(32'h0000_0000, 32'h204, 22'h000240);
    checks++;
    if (s_fired !== 1'b1) begin
      errors++;
      $display("FAIL mul_fire got fire=%b with add load want 1", s_fired);
    end
    for (int k = 0; k < 3; k++) begin
      advance();
      checks++;
      if ({s_in_ready, s_out_valid} !== 2'b00) begin
        errors++;
        $display("FAIL mul_bubble cycle %0d got in_ready=%b out_valid=%b want 0 0", k, s_in_ready, s_out_valid);
      end
    end
    advance();
    checks++;
    if (s_fired !== 1'b1 || s_ctrl !== 22'h000240) begin
      errors++;
      $display("FAIL add_after_mul got fire=%b ctrl=%h want 1 000240", s_fired, s_ctrl);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL muldiv_bundle got ctrl=%h instr=%h pc=%h want ctrl=%h instr=%h pc=%h", o.ctrl, o.instr, o.pc, e.ctrl, e.instr, e.pc);
      end
    end
  endtask

  task automatic test_stall_back_to_back();
    bundle_t e, o;
    out_ready = 1'b0;
    send(32'h0800_0000, 32'h300, 22'h000440);
    in_valid = 1'b1; in_instr = 32'h4800_0000; in_pc = 32'h304; drv_ctrl = 22'h200040;
    for (int k = 0; k < 5; k++) begin
      advance();
      checks++;
      if ({s_out_valid, s_in_ready, s_ctrl, s_instr, s_pc} !== {2'b10, 22'h000440, 32'h0800_0000, 32'h300}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid=%b rdy=%b ctrl=%h instr=%h pc=%h want 1 0 000440 08000000 300",
                 k, s_out_valid, s_in_ready, s_ctrl, s_instr, s_pc);
      end
    end
    out_ready = 1'b1;
    advance();
    in_valid = 1'b0;
    checks++;
    if ({s_fired, s_acc} !== 2'b11) begin
      errors++;
      $display("FAIL back_to_back got fire=%b accept=%b want 1 1", s_fired, s_acc);
    end
    flush_out(20);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stall_bundle got ctrl=%h instr=%h pc=%h want ctrl=%h instr=%h pc=%h", o.ctrl, o.instr, o.pc, e.ctrl, e.instr, e.pc);
      end
    end
  endtask

  task automatic test_flush();
    bundle_t e, o;
    out_ready = 1'b0;
    send(32'h3000_0000, 32'h400, 22'h080040);
    in_valid = 1'b1; in_instr = 32'h3800_0000; in_pc = 32'h404; drv_ctrl = 22'h040040;
    flush = 1'b1;
    advance();
    checks++;
    if (s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_accept got in_ready=%b want 0", s_in_ready);
    end
    flush = 1'b0; in_valid = 1'b0;
    advance();
    checks++;
    if ({s_out_valid, s_in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_kill got out_valid=%b in_ready=%b want 0 1", s_out_valid, s_in_ready);
    end
    out_ready = 1'b1;
    send(32'h1800_0000, 32'h410, 22'h002040);
    send(32'h0000_0000, 32'h414, 22'h000240);
    advance();
    in_valid = 1'b1; in_instr = 32'h3800_0000; in_pc = 32'h418; drv_ctrl = 22'h040040;
    flush = 1'b1;
    advance();
    checks++;
    if (s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy_no_accept got in_ready=%b want 0", s_in_ready);
    end
    flush = 1'b0; in_valid = 1'b0;
    advance();
    checks++;
    if ({s_out_valid, s_in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_busy_clear got out_valid=%b in_ready=%b want 0 1", s_out_valid, s_in_ready);
    end
    send(32'h3800_0000, 32'h41C, 22'h040040);
    flush_out(20);
    checks++;
    if (exp_q.size() != 2) begin
      errors++;
      $display("FAIL flush_fire_count got %0d fires want 2", exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL flush_bundle got ctrl=%h instr=%h pc=%h want ctrl=%h instr=%h pc=%h", o.ctrl, o.instr, o.pc, e.ctrl, e.instr, e.pc);
      end
    end
  endtask

`ifdef CTRL_ILLEGAL_TRAP_EN
  task automatic test_illegal();
    out_ready = 1'b1;
    send(32'hF800_0000, 32'h500, 22'h000000);
    checks++;
    if ({ctrl_bus, illegal_op} !== {22'h000000, 1'b1}) begin
      errors++;
      $display("FAIL illegal_flag got ctrl=%h illegal_op=%b want 000000 1", ctrl_bus, illegal_op);
    end
    send(32'h0000_0000, 32'h504, 22'h000240);
    advance();
    checks++;
    if ({illegal_op, illegal_seen} !== 2'b01) begin
      errors++;
      $display("FAIL illegal_sticky got op=%b seen=%b want 0 1", illegal_op, illegal_seen);
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode_sweep();
    test_muldiv();
    test_stall_back_to_back();
    test_flush();
`ifdef CTRL_ILLEGAL_TRAP_EN
    test_illegal();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
